// File: rtl/jtag_led_matrix_driver_pkg.sv
`default_nettype none
// ============================================================================
// Package  : jtag_led_matrix_driver_pkg
// Purpose  : Matrix geometry and row/column helpers for the LED frame scanner.
// Revision : 1.0
// ============================================================================
package jtag_led_matrix_driver_pkg;

    localparam int NR_ROWS    = 9;
    localparam int NR_COLUMNS = 4;
    localparam int FRAME_BITS = NR_ROWS * NR_COLUMNS;
    localparam int COL_W      = 2;

    localparam logic [NR_COLUMNS-1:0] COLUMNS_OFF = 4'b1111;

    typedef logic [NR_ROWS-1:0]    row_t;
    typedef logic [FRAME_BITS-1:0] frame_t;
    typedef logic [COL_W-1:0]      col_t;
    typedef logic [NR_COLUMNS-1:0] colsel_t;

    // Active-low one-hot column strobe.
    function automatic colsel_t column_select(input col_t col);
        column_select      = COLUMNS_OFF;
        column_select[col] = 1'b0;
    endfunction

    // Row pattern of one column; frame bit c*NR_ROWS+r is row r of column c.
    function automatic row_t frame_row(input frame_t frame, input col_t col);
        frame_row = '0;
        for (int c = 0; c < NR_COLUMNS; c++) begin
            if (col == COL_W'(c)) begin
                frame_row = frame[c*NR_ROWS +: NR_ROWS];
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_led_matrix_driver_toggle_sync.sv
`default_nettype none
// ============================================================================
// Module   : jtag_led_matrix_driver_toggle_sync
// Purpose  : Two-flop synchronizer for a toggle handshake; one-cycle pulse per flip.
// Revision : 1.0
// ============================================================================
module jtag_led_matrix_driver_toggle_sync
    import jtag_led_matrix_driver_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic toggle_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/jtag_led_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module   : jtag_led_matrix_driver
// Purpose  : Scans a double-buffered 36-bit JTAG frame onto the 9x4 LED matrix.
// Revision : 1.0
// ============================================================================
module jtag_led_matrix_driver
    import jtag_led_matrix_driver_pkg::*;
#(
    parameter int CLOCK_DIVIDE = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] frameData,
    input  logic                  frameToggle,
    input  logic                  enable,
    output logic [NR_ROWS-1:0]    LEDS,
    output logic [NR_COLUMNS-1:0] LEDS_columns,
    output logic                  frameLoaded,
    output logic [7:0]            frameCount
);

    localparam int PRE_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLOCK_DIVIDE - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam col_t             COL_LAST  = col_t'(NR_COLUMNS - 1);

    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    col_t             column_q,    column_d;
    frame_t           shadow_q,    shadow_d;
    frame_t           active_q,    active_d;
    logic             pending_q,   pending_d;
    logic             enable_q;
    row_t             leds_q,      leds_d;
    colsel_t          columns_q,   columns_d;
    logic             loaded_q,    loaded_d;
    logic [7:0]       count_q,     count_d;

    logic w_new_frame;
    logic w_scan_end;
    logic w_swap;

    jtag_led_matrix_driver_toggle_sync u_toggle_sync (
        .clk_i    (clock),
        .rst_i    (reset),
        .toggle_i (frameToggle),
        .pulse_o  (w_new_frame)
    );

    always_comb begin
        prescaler_d = '0;
        column_d    = '0;
        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q;
        leds_d      = '0;
        columns_d   = COLUMNS_OFF;

        w_scan_end = enable && (prescaler_q == PRE_LAST) && (column_q == COL_LAST);
        // While disabled, the swap waits one cycle so the blanked outputs land first.
        w_swap     = pending_q && (w_scan_end || (!enable && !enable_q));

        if (enable) begin
            if (prescaler_q == PRE_LAST) begin
                column_d = (column_q == COL_LAST) ? col_t'(0) : column_q + col_t'(1);
            end else begin
                prescaler_d = prescaler_q + PRE_W'(1);
                column_d    = column_q;
            end
            columns_d = column_select(column_q);
            if (prescaler_q >= PRE_BLANK) begin
                leds_d = frame_row(active_q, column_q);
            end
        end

        // A swap coinciding with a new frame takes the old shadow and stays pending.
        if (w_swap) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (w_new_frame) begin
            shadow_d  = frameData;
            pending_d = 1'b1;
        end

        loaded_d = w_swap;
        count_d  = count_q + (w_swap ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_q <= '0;
            column_q    <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            enable_q    <= 1'b0;
            leds_q      <= '0;
            columns_q   <= COLUMNS_OFF;
            loaded_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            column_q    <= column_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            enable_q    <= enable;
            leds_q      <= leds_d;
            columns_q   <= columns_d;
            loaded_q    <= loaded_d;
            count_q     <= count_d;
        end
    end

    assign LEDS         = leds_q;
    assign LEDS_columns = columns_q;
    assign frameLoaded  = loaded_q;
    assign frameCount   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_led_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_led_matrix_driver
// Purpose  : Self-checking bench for the LED matrix scanner (CLOCK_DIVIDE=8, BLANK_CYCLES=2).
// Revision : 1.0
// ============================================================================
module tb_jtag_led_matrix_driver;

    localparam int CD   = 8;
    localparam int BL   = 2;
    localparam int SCAN = CD * 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [35:0] frameData;
    logic        frameToggle;
    logic        enable;
    logic [8:0]  LEDS;
    logic [3:0]  LEDS_columns;
    logic        frameLoaded;
    logic [7:0]  frameCount;

    jtag_led_matrix_driver #(
        .CLOCK_DIVIDE (CD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frameData    (frameData),
        .frameToggle  (frameToggle),
        .enable       (enable),
        .LEDS         (LEDS),
        .LEDS_columns (LEDS_columns),
        .frameLoaded  (frameLoaded),
        .frameCount   (frameCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] leds;
        logic [3:0] cols;
        logic       loaded;
        logic [7:0] count;
    } exp_t;

    typedef struct {
        int          edge_no;
        logic [35:0] data;
    } load_t;

    exp_t  sb_q[$];
    load_t load_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int k      = 0;

    logic [35:0] m_active  = '0;
    logic [35:0] m_shadow  = '0;
    logic        m_pending = 1'b0;
    logic        m_en_prev = 1'b0;
    logic [7:0]  m_count   = '0;

    // Model the edge about to happen, queue its expected outputs, then clock it.
    task automatic tick();
        exp_t e;
        logic swap;
        logic load;
        int   col;
        int   pre;
        if (reset) begin
            e = '{leds: 9'h0, cols: 4'hF, loaded: 1'b0, count: 8'h0};
            m_active  = '0;
            m_shadow  = '0;
            m_pending = 1'b0;
            m_en_prev = 1'b0;
            m_count   = '0;
            k         = 0;
            load_q.delete();
        end else begin
            col  = k / CD;
            pre  = k % CD;
            swap = m_pending && ((enable && k == SCAN - 1) || (!enable && !m_en_prev));
            load = (load_q.size() > 0) && (load_q[0].edge_no == cyc + 1);
            e.leds = (enable && pre >= BL) ? m_active[col*9 +: 9] : 9'h0;
            e.cols = enable ? ~(4'b0001 << col) : 4'hF;
            if (swap) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
                m_count   = m_count + 8'd1;
            end
            if (load) begin
                m_shadow  = load_q[0].data;
                m_pending = 1'b1;
                void'(load_q.pop_front());
            end
            e.loaded  = swap;
            e.count   = m_count;
            m_en_prev = enable;
            k         = enable ? (k + 1) % SCAN : 0;
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    always @(posedge clock) begin : monitor
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (LEDS !== e.leds) begin
                errors++;
                $display("FAIL sb_leds cyc=%0d got=%h expected=%h", cyc, LEDS, e.leds);
            end
            checks++;
            if (LEDS_columns !== e.cols) begin
                errors++;
                $display("FAIL sb_columns cyc=%0d got=%b expected=%b", cyc, LEDS_columns, e.cols);
            end
            checks++;
            if (frameLoaded !== e.loaded) begin
                errors++;
                $display("FAIL sb_loaded cyc=%0d got=%b expected=%b", cyc, frameLoaded, e.loaded);
            end
            checks++;
            if (frameCount !== e.count) begin
                errors++;
                $display("FAIL sb_count cyc=%0d got=%0d expected=%0d", cyc, frameCount, e.count);
            end
        end
    end

    task automatic flip(input logic [35:0] data);
        load_t l;
        frameData   = data;
        frameToggle = ~frameToggle;
        l.edge_no   = cyc + 3;
        l.data      = data;
        load_q.push_back(l);
    endtask

    task automatic wait_loaded(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            got = (frameLoaded === 1'b1);
        end
    endtask

    task automatic wait_k(input int target);
        for (int i = 0; i < 2 * SCAN && k != target; i++) begin
            tick();
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        frameToggle = 1'b0;
        frameData   = '0;
        repeat (3) tick();
        checks++;
        if (LEDS !== 9'h0) begin
            errors++;
            $display("FAIL reset_leds got=%h expected=000", LEDS);
        end
        checks++;
        if (LEDS_columns !== 4'b1111) begin
            errors++;
            $display("FAIL reset_columns got=%b expected=1111", LEDS_columns);
        end
        checks++;
        if (frameCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d expected=0", frameCount);
        end
        checks++;
        if (frameLoaded !== 1'b0) begin
            errors++;
            $display("FAIL reset_loaded got=%b expected=0", frameLoaded);
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] pat [4];
        int col;
        pat    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < SCAN; i++) begin
            col = k / CD;
            tick();
            checks++;
            if (LEDS_columns !== pat[col]) begin
                errors++;
                $display("FAIL idle_columns step=%0d got=%b expected=%b", i, LEDS_columns, pat[col]);
            end
            checks++;
            if (LEDS !== 9'h0) begin
                errors++;
                $display("FAIL idle_leds step=%0d got=%h expected=000", i, LEDS);
            end
        end
        checks++;
        if (frameCount !== 8'd0) begin
            errors++;
            $display("FAIL idle_count got=%0d expected=0", frameCount);
        end
    endtask

    task automatic test_single_frame();
        logic [8:0] rows [4];
        bit got;
        int col;
        int pre;
        rows = '{9'h001, 9'h0AA, 9'h000, 9'h155};
        flip(36'hAA8015401);
        wait_loaded(2 * SCAN, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL single_loaded_timeout got=0 expected=1");
        end
        checks++;
        if (frameCount !== 8'd1) begin
            errors++;
            $display("FAIL single_count got=%0d expected=1", frameCount);
        end
        for (int i = 0; i < SCAN; i++) begin
            col = k / CD;
            pre = k % CD;
            tick();
            if (i == 0) begin
                checks++;
                if (frameLoaded !== 1'b0) begin
                    errors++;
                    $display("FAIL single_pulse_width got=%b expected=0", frameLoaded);
                end
            end
            checks++;
            if (LEDS !== ((pre < BL) ? 9'h000 : rows[col])) begin
                errors++;
                $display("FAIL single_rows col=%0d pre=%0d got=%h expected=%h",
                         col, pre, LEDS, (pre < BL) ? 9'h000 : rows[col]);
            end
        end
    endtask

    task automatic test_multi_toggle();
        bit got;
        int col;
        int pre;
        flip(36'h0000001FF);
        repeat (4) tick();
        flip(36'hFF8000000);
        wait_loaded(2 * SCAN, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL multi_loaded_timeout got=0 expected=1");
        end
        checks++;
        if (frameCount !== 8'd2) begin
            errors++;
            $display("FAIL multi_count got=%0d expected=2", frameCount);
        end
        for (int i = 0; i < SCAN; i++) begin
            col = k / CD;
            pre = k % CD;
            tick();
            checks++;
            if (LEDS !== ((col == 3 && pre >= BL) ? 9'h1FF : 9'h000)) begin
                errors++;
                $display("FAIL multi_rows col=%0d pre=%0d got=%h", col, pre, LEDS);
            end
        end
        checks++;
        if (frameCount !== 8'd2) begin
            errors++;
            $display("FAIL multi_count_after got=%0d expected=2", frameCount);
        end
    endtask

    task automatic test_swap_collision();
        bit got;
        int col;
        int pre;
        wait_k(1);
        flip(36'h000000155);
        wait_k(SCAN - 3);
        flip(36'h007FC0000);
        wait_loaded(8, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL collide_loaded_timeout got=0 expected=1");
        end
        checks++;
        if (frameCount !== 8'd3) begin
            errors++;
            $display("FAIL collide_count1 got=%0d expected=3", frameCount);
        end
        for (int i = 0; i < SCAN; i++) begin
            col = k / CD;
            pre = k % CD;
            tick();
            checks++;
            if (LEDS !== ((col == 0 && pre >= BL) ? 9'h155 : 9'h000)) begin
                errors++;
                $display("FAIL collide_old_rows col=%0d pre=%0d got=%h", col, pre, LEDS);
            end
        end
        checks++;
        if (frameLoaded !== 1'b1 || frameCount !== 8'd4) begin
            errors++;
            $display("FAIL collide_second_swap loaded=%b count=%0d expected loaded=1 count=4",
                     frameLoaded, frameCount);
        end
        for (int i = 0; i < SCAN; i++) begin
            col = k / CD;
            pre = k % CD;
            tick();
            checks++;
            if (LEDS !== ((col == 2 && pre >= BL) ? 9'h1FF : 9'h000)) begin
                errors++;
                $display("FAIL collide_new_rows col=%0d pre=%0d got=%h", col, pre, LEDS);
            end
        end
    endtask

    task automatic test_disable();
        wait_k(10);
        flip(36'h007FC0003);
        repeat (4) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (LEDS !== 9'h0 || LEDS_columns !== 4'b1111 || frameLoaded !== 1'b0) begin
            errors++;
            $display("FAIL disable_off leds=%h cols=%b loaded=%b expected leds=000 cols=1111 loaded=0",
                     LEDS, LEDS_columns, frameLoaded);
        end
        tick();
        checks++;
        if (frameLoaded !== 1'b1 || frameCount !== 8'd5) begin
            errors++;
            $display("FAIL disable_swap loaded=%b count=%0d expected loaded=1 count=5",
                     frameLoaded, frameCount);
        end
        repeat (3) tick();
        checks++;
        if (frameCount !== 8'd5 || LEDS_columns !== 4'b1111) begin
            errors++;
            $display("FAIL disable_hold count=%0d cols=%b expected count=5 cols=1111",
                     frameCount, LEDS_columns);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (LEDS_columns !== 4'b1110 || LEDS !== 9'h0) begin
            errors++;
            $display("FAIL reenable_first cols=%b leds=%h expected cols=1110 leds=000",
                     LEDS_columns, LEDS);
        end
        tick();
        checks++;
        if (LEDS !== 9'h0) begin
            errors++;
            $display("FAIL reenable_blank got=%h expected=000", LEDS);
        end
        tick();
        checks++;
        if (LEDS !== 9'h003) begin
            errors++;
            $display("FAIL reenable_data got=%h expected=003", LEDS);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pat [4];
        int col;
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wait_k(2 * CD + 4);
        checks++;
        if (LEDS !== 9'h1FF || LEDS_columns !== 4'b1011) begin
            errors++;
            $display("FAIL premid_col2 leds=%h cols=%b expected leds=1ff cols=1011",
                     LEDS, LEDS_columns);
        end
        reset       = 1'b1;
        frameToggle = 1'b0;
        tick();
        checks++;
        if (LEDS !== 9'h0 || LEDS_columns !== 4'b1111 || frameCount !== 8'd0) begin
            errors++;
            $display("FAIL midreset leds=%h cols=%b count=%0d expected leds=000 cols=1111 count=0",
                     LEDS, LEDS_columns, frameCount);
        end
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < SCAN; i++) begin
            col = k / CD;
            tick();
            checks++;
            if (LEDS !== 9'h0 || LEDS_columns !== pat[col]) begin
                errors++;
                $display("FAIL restart step=%0d leds=%h cols=%b expected leds=000 cols=%b",
                         i, LEDS, LEDS_columns, pat[col]);
            end
        end
        checks++;
        if (frameCount !== 8'd0) begin
            errors++;
            $display("FAIL restart_count got=%0d expected=0", frameCount);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frameToggle = 1'b0;
        frameData   = '0;
        test_reset();
        test_idle_scan();
        test_single_frame();
        test_multi_toggle();
        test_swap_collision();
        test_disable();
        test_reset_mid();
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jtag_led_matrix_driver.md
Name: jtag_led_matrix_driver

Overview:
Downstream consumer of the JTAG user-register logic: takes the 36-bit LED frame captured on JTAG update and scans it onto the 9-row × 4-column LED matrix of the board. Runs in the system clock domain. The frame arrives with a toggle handshake launched from the JTCK domain. The frame is double-buffered and swapped only at the end of a full scan, so a displayed frame never tears.

Parameters:
CLOCK_DIVIDE, 12000, clock cycles each column is active (1 kHz/column at 12 MHz)
BLANK_CYCLES, 16, cycles at start of each column slot with rows forced off (anti-ghosting); must be < CLOCK_DIVIDE

Ports:
clock  in  1  system clock
reset  in  1  reset
frameData  in  36  frame from JTAG register; bit c*9+r = row r of column c; held stable between toggles by the JTAG side
frameToggle  in  1  asynchronous (JTCK domain); flips once per new frame
enable  in  1  display enable
LEDS  out  9  row drive, active-high
LEDS_columns  out  4  column select, active-low one-hot
frameLoaded  out  1  one-cycle pulse when a new frame becomes active
frameCount  out  8  number of frames made active, wraps 255→0

Interface decision: one clock (clock); reset is synchronous and active-high (reset).

Behaviour:
- Reset (sync, active-high): LEDS=0, LEDS_columns=4'b1111, frameLoaded=0, frameCount=0. Prescaler, column index, shadow/active buffers, pending flag and the sync flops are all cleared. Reset mid-scan aborts immediately and takes effect on the next edge.
- Toggle sync:
  - Two flops, then a "previous" flop.
  - A new frame is detected when sync2 != prev.
  - On that cycle: shadow <= frameData and pending <= 1.
  - Latency from the toggle edge to the shadow load is 3 clocks.
- Scan state:
  - Prescaler counts 0..CLOCK_DIVIDE-1.
  - At wrap, column advances 0→1→2→3→0.
- Swap point: prescaler==CLOCK_DIVIDE-1 and column==3 and pending. Then:
  - active <= shadow
  - pending <= 0
  - frameLoaded pulses on the next cycle
  - frameCount++
- Simultaneous new-frame detect and swap:
  - The swap takes the old shadow.
  - The shadow loads the new data and pending stays 1.
  - The new data is shown after the next full scan.
- Multiple toggles within one scan: only the last frame is shown, and frameCount increments once.
- Outputs are registered, one cycle after the counter state:
  - LEDS_columns: bit c = 0 for the active column c, all others 1.
  - LEDS = active[c*9 +: 9], except LEDS=0 while prescaler < BLANK_CYCLES.
- enable=0:
  - LEDS=0 and LEDS_columns=4'b1111.
  - Prescaler and column are held at 0.
  - Shadow loading continues.
  - If pending, the swap happens on the next cycle (with frameLoaded and frameCount++), so the latest frame is ready on re-enable.
- enable 0→1: the scan starts at column 0, prescaler 0, in the blank phase.

Decomposition:
- Shared package: NR_ROWS=9, NR_COLUMNS=4, FRAME_BITS=36, COLUMNS_OFF=4'b1111.
- Sub-module toggle_sync: 2-flop synchronizer plus edge detect, outputs a one-cycle pulse. It is reusable for other JTCK→clock handshakes.
- Everything else stays in jtag_led_matrix_driver.

Test Plan (CLOCK_DIVIDE=8, BLANK_CYCLES=2):
1. Reset held 3 cycles, then release with enable=1 and no toggle → LEDS_columns cycles 1110,1101,1011,0111 every 8 clocks; LEDS=0 throughout; frameCount=0.
2. frameData=36'hAA8015401, flip toggle → swap at the end of the current scan, frameLoaded one pulse, frameCount=1. In the next scan, after the 2 blank cycles of each slot, LEDS shows:
   - column 0: 9'h001
   - column 1: 9'h0AA
   - column 2: 9'h000
   - column 3: 9'h155
3. Two toggles within one scan (36'h0000001FF then 36'hFF8000000) → only column 3 = 9'h1FF is displayed; frameCount increments by exactly 1.
4. Toggle timed so its detect lands on the swap cycle → the previous shadow is displayed for one scan, then the new frame; frameCount +2 total.
5. enable=0 mid-scan with a pending frame → outputs off the next cycle, swap on the following cycle (frameCount+1). Re-enable → column 0 with LEDS=0 for 2 cycles, then the new data.
6. reset asserted mid-column-2 → next cycle LEDS=0 and LEDS_columns=1111; the active frame is cleared (all rows off after restart); frameCount=0.
